qu_frontend_ctrl: RTL and testbench
===================================

Name: qu_frontend_ctrl

Overview:
- Sequencing controller for the Qu front end (IF -> ID -> MP -> RN) and the scheduler enable.
- Replaces hand-driven stage stalls and schedule_en with an FSM: post-reset hold, pipeline fill, run, global stall, flush.
- Folds FIFO backpressure into per-stage stalls.
- Sits beside qu_core's front-end pipeline; drives the same stall and schedule_en inputs.

Parameters:
- FIFO_MP_RN_DEPTH, 16, depth of the MP->RN FIFO; sizes mp_rn_count.
- RESET_HOLD_CYCLES, 4, cycles every stage is held stalled after reset release; must be >= 1.
- SCHED_THRESHOLD, 4, MP->RN occupancy that enables scheduling in FILL; range 1..FIFO_MP_RN_DEPTH.
- FILL_TIMEOUT, 20, maximum cycles spent in FILL before forcing RUN; must be >= 1.
- FLUSH_CYCLES, 2, length of the flush pulse; must be >= 1.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_req  in  1  global stall request, level.
- flush_req  in  1  flush request, single-cycle pulse.
- if_id_full  in  1  IF->ID FIFO full.
- id_mp_full  in  1  ID->MP FIFO full.
- mp_rn_full  in  1  MP->RN FIFO full.
- mp_rn_count  in  $clog2(FIFO_MP_RN_DEPTH+1)  MP->RN occupancy.
- rn_ready  in  1  backend accepts renamed uops.
- if_stall, id_stall, mp_stall, rn_stall  out  1 each  per-stage stalls.
- schedule_en  out  1  scheduler enable.
- flush  out  1  front-end flush.
- state_o  out  3  current FSM state encoding.

Behaviour:
- States and encodings: HOLD=0, FILL=1, RUN=2, STALL=3, FLUSH=4.
- Registers: one cycle counter, $clog2 of the max parameter plus 1 bits wide; ret_state (FILL or RUN).
- Reset (rst_n=0, asynchronous):
  - state=HOLD, counter=0, ret_state=FILL.
  - schedule_en=0, flush=0.
  - All four stage stalls = 1.
- hold_all = state is HOLD, STALL or FLUSH. This is decoded from registered state only.
- Stage stalls are combinational:
  - if_stall = hold_all | if_id_full.
  - id_stall = hold_all | id_mp_full.
  - mp_stall = hold_all | mp_rn_full.
  - rn_stall = hold_all | ~rn_ready.
- schedule_en and flush are registered Moore outputs:
  - schedule_en = 1 only while state==RUN.
  - flush = 1 only while state==FLUSH.
  - Both change on the same edge that changes state.
- HOLD:
  - counter increments each cycle.
  - At counter==RESET_HOLD_CYCLES-1: go to FILL, counter=0.
  - flush_req and stall_req are ignored in HOLD.
- FILL:
  - counter increments each cycle.
  - Go to RUN when mp_rn_count >= SCHED_THRESHOLD, or when counter==FILL_TIMEOUT-1.
- RUN: steady state; remains until stall_req or flush_req.
- Transition priority in FILL, RUN and STALL: flush_req > stall_req > normal transition.
- Entering STALL: from FILL or RUN when stall_req=1. Set ret_state to the originating state. FILL's counter is frozen.
- STALL exit: leave when stall_req=0. Return to ret_state; FILL resumes with the frozen counter.
- flush_req in FILL, RUN or STALL: go to FLUSH, counter=0.
- FLUSH:
  - Lasts exactly FLUSH_CYCLES cycles, then goes to FILL with counter=0 and ret_state=FILL.
  - A flush_req arriving during FLUSH restarts counter=0, extending the flush.
  - stall_req is ignored in FLUSH. If stall_req is still high on exit, the next cycle goes FILL -> STALL.
- Simultaneous conditions in FILL: threshold/timeout together with stall_req gives STALL with ret_state=FILL. Scheduling never starts while stall_req is high.
- Reset asserted mid-operation (any state): immediate return to reset values. No flush pulse is generated.

Optional Feature:
- Macro: QU_FRONTEND_PERF_EN.
- Defined:
  - Adds output perf_stall_cycles (32) and perf_flush_count (16).
  - perf_stall_cycles increments every cycle that state is STALL or FLUSH.
  - perf_flush_count increments on every entry into FLUSH, including a restart.
  - Both counters saturate at their maximum and reset to 0 on rst_n.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- The qu_common package holds:
  - Typedef qu_fe_state_t, a 3-bit enum of HOLD/FILL/RUN/STALL/FLUSH.
  - Constant QU_FE_STATE_WIDTH = 3.
- Natural sub-module qu_sat_counter (parameterised width, inc, clr, saturating). It is instantiated only under QU_FRONTEND_PERF_EN.

Test Plan:
- Reset release with defaults:
  - All stalls stay 1 for 4 cycles; state_o goes 0 -> 1 on the 4th edge.
  - schedule_en stays 0 until mp_rn_count=4 is observed in FILL; it rises the next edge.
- mp_rn_count held at 0 in FILL: RUN and schedule_en=1 after exactly 20 FILL cycles.
- RUN, then stall_req high for 3 cycles:
  - STALL for 3 cycles with all stalls 1 and schedule_en=0.
  - Returns to RUN one edge after stall_req falls.
- flush_req pulse in RUN: flush=1 for 2 cycles, schedule_en=0, state FLUSH, then FILL. A second pulse in flush cycle 1 extends flush to 3 cycles total.
- In RUN with id_mp_full=1 and rn_ready=0: only id_stall and rn_stall are 1; schedule_en stays 1.
- rst_n asserted mid-FLUSH: flush, schedule_en and state clear immediately (asynchronously); stalls go 1. With QU_FRONTEND_PERF_EN, both perf counters read 0.

Source files
------------

// File: rtl/qu_common.sv
// Shared types for the Qu front end.
// Holds the front-end sequencer state encoding.
package qu_common;

  localparam int QU_FE_STATE_WIDTH = 3;

  typedef enum logic [QU_FE_STATE_WIDTH-1:0] {
    QU_FE_HOLD  = 3'd0,
    QU_FE_FILL  = 3'd1,
    QU_FE_RUN   = 3'd2,
    QU_FE_STALL = 3'd3,
    QU_FE_FLUSH = 3'd4
  } qu_fe_state_t;

  function automatic int qu_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qu_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used by the front-end performance counters.
module qu_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/qu_frontend_ctrl.sv
// Qu front-end sequencer: hold, fill, run, stall and flush.
// QU_FRONTEND_PERF_EN adds stall-cycle and flush-count outputs.
module qu_frontend_ctrl
  import qu_common::*;
#(
  parameter int FIFO_MP_RN_DEPTH  = 16,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int SCHED_THRESHOLD   = 4,
  parameter int FILL_TIMEOUT      = 20,
  parameter int FLUSH_CYCLES      = 2,
  localparam int MW = $clog2(FIFO_MP_RN_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_req,
  input  logic          flush_req,
  input  logic          if_id_full,
  input  logic          id_mp_full,
  input  logic          mp_rn_full,
  input  logic [MW-1:0] mp_rn_count,
  input  logic          rn_ready,
  output logic          if_stall,
  output logic          id_stall,
  output logic          mp_stall,
  output logic          rn_stall,
  output logic          schedule_en,
  output logic          flush,
  output logic [2:0]    state_o
`ifdef QU_FRONTEND_PERF_EN
  ,
  output logic [31:0]   perf_stall_cycles,
  output logic [15:0]   perf_flush_count
`endif
);

  localparam int CMAX = qu_max3(RESET_HOLD_CYCLES,
                                FILL_TIMEOUT,
                                FLUSH_CYCLES);
  localparam int CW = $clog2(CMAX + 1);

  qu_fe_state_t  state_q, state_d;
  qu_fe_state_t  ret_q, ret_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_all;
  logic          fill_done;

  assign fill_done =
    (mp_rn_count >= MW'(SCHED_THRESHOLD)) ||
    (cnt_q == CW'(FILL_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      QU_FE_HOLD: begin
        if (cnt_q == CW'(RESET_HOLD_CYCLES - 1)) begin
          state_d = QU_FE_FILL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      QU_FE_FILL: begin
        if (flush_req) begin
          state_d = QU_FE_FLUSH;
          cnt_d   = '0;
        end else if (stall_req) begin
          // counter stays frozen so FILL resumes where it left off
          state_d = QU_FE_STALL;
          ret_d   = QU_FE_FILL;
        end else if (fill_done) begin
          state_d = QU_FE_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      QU_FE_RUN: begin
        if (flush_req) begin
          state_d = QU_FE_FLUSH;
          cnt_d   = '0;
        end else if (stall_req) begin
          state_d = QU_FE_STALL;
          ret_d   = QU_FE_RUN;
        end
      end
      QU_FE_STALL: begin
        if (flush_req) begin
          state_d = QU_FE_FLUSH;
          cnt_d   = '0;
        end else if (!stall_req) begin
          state_d = ret_q;
        end
      end
      QU_FE_FLUSH: begin
        if (flush_req) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
          state_d = QU_FE_FILL;
          ret_d   = QU_FE_FILL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = QU_FE_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= QU_FE_HOLD;
      ret_q       <= QU_FE_FILL;
      cnt_q       <= '0;
      schedule_en <= 1'b0;
      flush       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      schedule_en <= (state_d == QU_FE_RUN);
      flush       <= (state_d == QU_FE_FLUSH);
    end
  end

  assign hold_all = (state_q == QU_FE_HOLD) ||
                    (state_q == QU_FE_STALL) ||
                    (state_q == QU_FE_FLUSH);

  assign if_stall = hold_all | if_id_full;
  assign id_stall = hold_all | id_mp_full;
  assign mp_stall = hold_all | mp_rn_full;
  assign rn_stall = hold_all | ~rn_ready;
  assign state_o  = state_q;

`ifdef QU_FRONTEND_PERF_EN
  logic stall_cyc;
  logic flush_entry;

  assign stall_cyc = (state_q == QU_FE_STALL) ||
                     (state_q == QU_FE_FLUSH);
  // a restart inside FLUSH counts as a fresh entry
  assign flush_entry = (state_d == QU_FE_FLUSH) &&
                       ((state_q != QU_FE_FLUSH) || flush_req);

  qu_sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_cyc),
    .clr   (1'b0),
    .count (perf_stall_cycles)
  );

  qu_sat_counter #(.WIDTH(16)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_entry),
    .clr   (1'b0),
    .count (perf_flush_count)
  );
`endif

endmodule

// File: tb/tb_qu_frontend_ctrl.sv
// Scoreboard bench for qu_frontend_ctrl.
// Expected state per edge is queued at drive time, checked after the edge.
module tb_qu_frontend_ctrl;

  localparam int S_HOLD  = 0;
  localparam int S_FILL  = 1;
  localparam int S_RUN   = 2;
  localparam int S_STALL = 3;
  localparam int S_FLUSH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall_req = 1'b0;
  logic       flush_req = 1'b0;
  logic       if_id_full = 1'b0;
  logic       id_mp_full = 1'b0;
  logic       mp_rn_full = 1'b0;
  logic       rn_ready = 1'b1;
  logic [4:0] mp_rn_count = '0;
  logic       if_stall, id_stall, mp_stall, rn_stall;
  logic       schedule_en, flush;
  logic [2:0] state_o;
`ifdef QU_FRONTEND_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int n_flush = 0;
  int mon_e;
  int sb[$];

  always #5 clk = ~clk;

  qu_frontend_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .if_id_full  (if_id_full),
    .id_mp_full  (id_mp_full),
    .mp_rn_full  (mp_rn_full),
    .mp_rn_count (mp_rn_count),
    .rn_ready    (rn_ready),
    .if_stall    (if_stall),
    .id_stall    (id_stall),
    .mp_stall    (mp_stall),
    .rn_stall    (rn_stall),
    .schedule_en (schedule_en),
    .flush       (flush),
    .state_o     (state_o)
`ifdef QU_FRONTEND_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_stalls(input int st);
    logic h;
    h = (st == S_HOLD) || (st == S_STALL) || (st == S_FLUSH);
    return {h | if_id_full, h | id_mp_full,
            h | mp_rn_full, h | ~rn_ready};
  endfunction

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("state", 32'(state_o), 32'(mon_e));
      chk("sched", 32'(schedule_en), 32'(mon_e == S_RUN));
      chk("flush", 32'(flush), 32'(mon_e == S_FLUSH));
      chk("stalls",
          32'({if_stall, id_stall, mp_stall, rn_stall}),
          32'(exp_stalls(mon_e)));
    end
  end

  task automatic cyc(input logic sr, input logic fr,
                     input logic [4:0] mc, input int st);
    @(negedge clk);
    stall_req   = sr;
    flush_req   = fr;
    mp_rn_count = mc;
    sb.push_back(st);
    if (fr && st == S_FLUSH) n_flush++;
  endtask

  initial begin
    #12;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_sched", 32'(schedule_en), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_stalls",
        32'({if_stall, id_stall, mp_stall, rn_stall}), 32'hF);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // HOLD ignores requests, leaves on the 4th edge
    cyc(1, 0, 0, S_HOLD);
    cyc(0, 1, 0, S_HOLD);
    cyc(0, 0, 4, S_HOLD);
    cyc(0, 0, 0, S_FILL);
    // threshold boundary
    cyc(0, 0, 3, S_FILL);
    cyc(0, 0, 0, S_FILL);
    cyc(0, 0, 4, S_RUN);
    cyc(0, 0, 0, S_RUN);
    // global stall from RUN
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, S_STALL);
    cyc(0, 0, 0, S_RUN);
    cyc(0, 0, 0, S_RUN);
    // FIFO backpressure in RUN
    @(negedge clk);
    id_mp_full = 1'b1;
    rn_ready   = 1'b0;
    sb.push_back(S_RUN);
    cyc(0, 0, 0, S_RUN);
    @(negedge clk);
    id_mp_full = 1'b0;
    rn_ready   = 1'b1;
    sb.push_back(S_RUN);
    // single flush, then FILL timeout
    cyc(0, 1, 0, S_FLUSH);
    cyc(0, 0, 0, S_FLUSH);
    cyc(0, 0, 0, S_FILL);
    for (int i = 0; i < 19; i++) cyc(0, 0, 0, S_FILL);
    cyc(0, 0, 0, S_RUN);
    // flush extended by a second pulse
    cyc(0, 1, 0, S_FLUSH);
    cyc(0, 1, 0, S_FLUSH);
    cyc(0, 0, 0, S_FLUSH);
    cyc(0, 0, 0, S_FILL);
    // stall inside FILL freezes the timeout counter
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, S_FILL);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, S_STALL);
    cyc(0, 0, 0, S_FILL);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, S_FILL);
    cyc(0, 0, 0, S_RUN);
    // flush beats stall; stall held across FLUSH exit
    cyc(1, 1, 0, S_FLUSH);
    cyc(1, 0, 0, S_FLUSH);
    cyc(1, 0, 4, S_FILL);
    cyc(1, 0, 4, S_STALL);
    cyc(1, 0, 4, S_STALL);
    cyc(0, 0, 4, S_FILL);
    cyc(0, 0, 4, S_RUN);
    // reset in the middle of FLUSH
    cyc(0, 1, 0, S_FLUSH);
    @(posedge clk);
    #3;
    chk("drain", 32'(sb.size()), 0);
    chk("pre_rst_flush", 32'(flush), 1);
`ifdef QU_FRONTEND_PERF_EN
    chk("perf_flush_cnt", 32'(perf_flush_count), 32'(n_flush));
`endif
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 0);
    chk("arst_flush", 32'(flush), 0);
    chk("arst_sched", 32'(schedule_en), 0);
    chk("arst_stalls",
        32'({if_stall, id_stall, mp_stall, rn_stall}), 32'hF);
`ifdef QU_FRONTEND_PERF_EN
    chk("arst_perf_stall", perf_stall_cycles, 0);
    chk("arst_perf_flush", 32'(perf_flush_count), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
